// File: rtl/systolic_result_collector.sv
// Result collector for the 4x4 systolic array: captures four shifted-out columns into a 4x4
// buffer, then drains it row-major as a valid/ready stream. Optional COLLECTOR_OVERRUN_EN.
module systolic_result_collector #(
  parameter int unsigned DW        = 8,
  parameter int unsigned CAP_DELAY = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [DW-1:0] shift_in_0,
  input  logic [DW-1:0] shift_in_1,
  input  logic [DW-1:0] shift_in_2,
  input  logic [DW-1:0] shift_in_3,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_row,
  output logic [1:0]    out_col,
  output logic          out_last
`ifdef COLLECTOR_OVERRUN_EN
  ,
  input  logic          overrun_clr,
  output logic          overrun
`endif
);

  typedef enum logic [1:0] {StIdle, StWait, StCapture, StDrain} state_e;

  state_e        state_q;
  logic [3:0]    dly_q;
  logic [1:0]    cap_q;
  logic [3:0]    idx_q;
  logic [DW-1:0] mem_q [4][4];
  logic [DW-1:0] lane  [4];
  logic          drain;

  assign lane[0] = shift_in_0;
  assign lane[1] = shift_in_1;
  assign lane[2] = shift_in_2;
  assign lane[3] = shift_in_3;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      dly_q   <= '0;
      cap_q   <= '0;
      idx_q   <= '0;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cap_q <= '0;
            if (CAP_DELAY == 0) begin
              state_q <= StCapture;
            end else begin
              state_q <= StWait;
              dly_q   <= 4'(CAP_DELAY - 1);
            end
          end
        end
        StWait: begin
          if (dly_q == 4'd0) state_q <= StCapture;
          else               dly_q   <= dly_q - 4'd1;
        end
        StCapture: begin
          // One column per cycle: lane r lands in row r, column cap_q.
          for (int r = 0; r < 4; r++) begin
            mem_q[r][cap_q] <= lane[r];
          end
          cap_q <= cap_q + 2'd1;
          if (cap_q == 2'd3) begin
            state_q <= StDrain;
            idx_q   <= '0;
          end
        end
        StDrain: begin
          if (out_ready) begin
            idx_q <= idx_q + 4'd1;
            if (idx_q == 4'd15) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign drain     = (state_q == StDrain);
  assign busy      = (state_q != StIdle);
  assign out_valid = drain;
  // Stream fields read zero outside DRAIN even though the buffer keeps its contents.
  assign out_data  = drain ? mem_q[idx_q[3:2]][idx_q[1:0]] : '0;
  assign out_row   = drain ? idx_q[3:2] : 2'd0;
  assign out_col   = drain ? idx_q[1:0] : 2'd0;
  assign out_last  = drain && (idx_q == 4'd15);

`ifdef COLLECTOR_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (!rstn)              overrun <= 1'b0;
    else if (start && busy) overrun <= 1'b1;
    else if (overrun_clr)   overrun <= 1'b0;
  end
`endif

endmodule

// File: doc/systolic_result_collector.md
Name: systolic_result_collector

Overview:
Downstream stage of the 4x4 systolic array wrapper. Captures the four 8-bit result lanes the array shifts out (one column per cycle over 4 cycles) into a 4x4 buffer. Then drains the buffer as a valid/ready element stream, row-major, to the host/bus interface. Sequenced by a start pulse from the top-level controller, issued when the array's output-shift phase begins.

Parameters:
DW, 8, width of each result element and of each lane
CAP_DELAY, 0, cycles between the sampled start pulse and the first captured column (0..15)

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  reset; synchronous, active-low
start  input  1  one-cycle pulse: array output shift begins
shift_in_0  input  DW  result lane row 0 (from array shift_out_0)
shift_in_1  input  DW  result lane row 1
shift_in_2  input  DW  result lane row 2
shift_in_3  input  DW  result lane row 3
busy  output  1  high whenever FSM not IDLE
out_valid  output  1  stream element valid
out_ready  input  1  downstream accepts element
out_data  output  DW  current element C[r][c]
out_row  output  2  r of current element
out_col  output  2  c of current element
out_last  output  1  high with element 15 (C[3][3])

Behaviour:
- Reset (rstn=0 at a rising edge): FSM to IDLE; delay counter, capture counter, drain index and all 16 buffer entries cleared to 0. busy, out_valid, out_last, out_data, out_row and out_col read 0. Reset has priority over every other event, mid-operation included. A partial capture or drain is abandoned with no further output.
- FSM states: IDLE, WAIT, CAPTURE, DRAIN.
- IDLE: start=1 -> WAIT with delay counter loaded to CAP_DELAY-1, or directly -> CAPTURE when CAP_DELAY=0.
- WAIT: counter decrements each cycle; at 0 -> CAPTURE.
- CAPTURE: capture counter k=0..3. Each cycle writes buf[r][k] <= shift_in_r for r=0..3. After k=3 -> DRAIN with drain index 0.
- Capture timing: start is high in cycle t. Columns are sampled at the ends of cycles t+CAP_DELAY+1 .. t+CAP_DELAY+4. The first out_valid is in cycle t+CAP_DELAY+5.
- DRAIN:
  - out_valid=1. out_data=buf[idx[3:2]][idx[1:0]], out_row=idx[3:2], out_col=idx[1:0], out_last=(idx==15).
  - idx increments only on out_valid&out_ready.
  - The handshake on idx==15 -> IDLE; out_valid drops the next cycle.
- Stream rules: while out_valid&!out_ready, out_data, out_row, out_col and out_last hold stable. out_ready may stay low indefinitely. out_ready is ignored outside DRAIN. Elements are never dropped or duplicated.
- start while busy=1: ignored; buffer and sequence unaffected. start in the same cycle as the final DRAIN handshake: ignored, because the FSM is not yet IDLE.
- Data path: pure storage; no arithmetic, width DW end to end.
- Buffer contents persist after DRAIN until the next capture or reset.
- busy=1 in WAIT, CAPTURE and DRAIN, including the cycle of the final handshake.

Optional Feature:
COLLECTOR_OVERRUN_EN
- Defined:
  - Adds output port overrun (1 bit) and input port overrun_clr (1 bit).
  - overrun is a sticky flag, set when start=1 while busy=1. It is cleared by overrun_clr=1 or reset; set has priority over clear in the same cycle. Reset value 0.
  - The ignored start is still ignored.
- Not defined: neither port exists, and start-while-busy is silently ignored.

Test Plan:
- Basic, CAP_DELAY=0, out_ready=1:
  - Stimulus: start in cycle 0; lanes r=0..3 carry 8'h10*r+c for c=0..3 in cycles 1..4.
  - Required: out_valid first in cycle 5; stream 00,01,02,03,10,...,33; out_last only with 8'h33 and row=3, col=3; busy low in cycle 21.
- Backpressure:
  - Stimulus: same data as basic; out_ready toggles 1,0,0,1,... and is held 0 for 10 cycles at idx 7.
  - Required: each element is held stable while not accepted; exactly 16 handshakes in order.
- Delay, CAP_DELAY=3:
  - Stimulus: lanes carry junk 8'hFF in cycles 1..3 and valid data in cycles 4..7.
  - Required: no 8'hFF in the stream; first out_valid in cycle 8.
- Start while busy:
  - Stimulus: pulse start again during CAPTURE and again during DRAIN.
  - Required: sequence and data unchanged. With COLLECTOR_OVERRUN_EN, overrun=1 from the cycle after the first extra start until overrun_clr.
- Reset mid-drain:
  - Stimulus: assert rstn=0 for 1 cycle after element 5.
  - Required: next cycle out_valid=0, busy=0, out_data=0. A new start then captures fresh data (values 8'hA0+...) and streams all 16 elements correctly.
- Back-to-back:
  - Stimulus: start in the cycle after busy falls.
  - Required: accepted; second matrix streams fully, with no element from the first.
